// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - Operand/handshake/result bundle between the E stage and the multiply/divide unit
interface e_mdu_if;
  logic        E_Start;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Req;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output E_Start, E_MDUOp, E_A, E_B, E_Req,
    input  E_Busy, E_HI, E_LO
  );

  modport slave (
    input  E_Start, E_MDUOp, E_A, E_B, E_Req,
    output E_Busy, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - Fixed-latency multiply/divide unit holding the architectural HI/LO pair
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  e_mdu_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] a, b, abs_a, abs_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] uq, ur, mq, mr, sq, sr;
  logic        launch;

  assign a = bus.E_A;
  assign b = bus.E_B;

  // Products: the low 64 bits of a sign/zero-extended 64x64 product are exact
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps cleanly without trapping
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Quotient/remainder datapath; a zero divisor yields zeros that are never committed
  always_comb begin
    uq = 32'd0;
    ur = 32'd0;
    mq = 32'd0;
    mr = 32'd0;
    if (b != 32'd0) begin
      uq = a / b;
      ur = a % b;
      mq = abs_a / abs_b;
      mr = abs_a % abs_b;
    end
    sq = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
    sr = a[31] ? (~mr + 32'd1) : mr;
  end

  assign launch = bus.E_Start && (bus.E_MDUOp >= OP_MULT) && (bus.E_MDUOp <= OP_DIVU)
                  && (state_q == S_IDLE) && !bus.E_Req;

  // Next-state: launch/MT writes when idle, countdown and commit when busy
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_BUSY;
          case (bus.E_MDUOp)
            OP_MULT: begin
              cnt_d     = 8'(MULT_CYCLES);
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_ok_d = 1'b1;
            end
            OP_MULTU: begin
              cnt_d     = 8'(MULT_CYCLES);
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_ok_d = 1'b1;
            end
            OP_DIV: begin
              cnt_d     = 8'(DIV_CYCLES);
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_ok_d = (b != 32'd0);
            end
            default: begin
              cnt_d     = 8'(DIV_CYCLES);
              pend_hi_d = ur;
              pend_lo_d = uq;
              pend_ok_d = (b != 32'd0);
            end
          endcase
        end else if (!bus.E_Req) begin
          if (bus.E_MDUOp == OP_MTHI) hi_d = a;
          if (bus.E_MDUOp == OP_MTLO) lo_d = a;
        end
      end
      default: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    endcase
  end

  // State register; reset also abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.E_Busy = (state_q == S_BUSY);
  assign bus.E_HI   = hi_q;
  assign bus.E_LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - Directed self-checking bench for e_mdu
module tb_e_mdu;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.E_Start = 1'b0;
    bus.E_MDUOp = 4'd0;
    bus.E_A     = 32'd0;
    bus.E_B     = 32'd0;
    bus.E_Req   = 1'b0;
  endtask

  // Launch an op, check busy for n cycles with HI/LO held, then check the result
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    old_hi = bus.E_HI;
    old_lo = bus.E_LO;
    bus.E_Start = 1'b1;
    bus.E_MDUOp = op;
    bus.E_A     = a;
    bus.E_B     = b;
    step();
    idle_inputs();
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.E_Busy}, 32'd1);
      if (i == n) begin
        chk({tag, "_hold_hi"}, bus.E_HI, old_hi);
        chk({tag, "_hold_lo"}, bus.E_LO, old_lo);
      end
      step();
    end
    chk({tag, "_done"}, {31'd0, bus.E_Busy}, 32'd0);
    chk({tag, "_hi"}, bus.E_HI, exp_hi);
    chk({tag, "_lo"}, bus.E_LO, exp_lo);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.E_Busy}, 32'd0);
    chk("rst_hi", bus.E_HI, 32'd0);
    chk("rst_lo", bus.E_LO, 32'd0);

    run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 4'd4, 32'd7,         32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf",4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",  4'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14);

    // DIV -100/7 with a MULT start at T+3 and an MTHI at T+4, both ignored
    bus.E_Start = 1'b1;
    bus.E_MDUOp = 4'd3;
    bus.E_A     = 32'hFFFF_FF9C;
    bus.E_B     = 32'd7;
    step();
    idle_inputs();
    step();
    step();
    bus.E_Start = 1'b1;
    bus.E_MDUOp = 4'd1;
    bus.E_A     = 32'd5;
    bus.E_B     = 32'd5;
    step();
    bus.E_Start = 1'b0;
    bus.E_MDUOp = 4'd5;
    bus.E_A     = 32'h0000_1234;
    step();
    idle_inputs();
    for (int i = 5; i <= 10; i++) begin
      chk("dist_busy", {31'd0, bus.E_Busy}, 32'd1);
      chk("dist_hold_hi", bus.E_HI, 32'd2);
      step();
    end
    chk("dist_done", {31'd0, bus.E_Busy}, 32'd0);
    chk("dist_hi", bus.E_HI, 32'hFFFF_FFFE);
    chk("dist_lo", bus.E_LO, 32'hFFFF_FFF2);

    // MTLO blocked by E_Req, then accepted; MTHI accepted
    bus.E_MDUOp = 4'd6;
    bus.E_A     = 32'h0000_CAFE;
    bus.E_Req   = 1'b1;
    step();
    chk("mtlo_req_lo", bus.E_LO, 32'hFFFF_FFF2);
    bus.E_Req = 1'b0;
    step();
    idle_inputs();
    chk("mtlo_lo", bus.E_LO, 32'h0000_CAFE);
    chk("mtlo_busy", {31'd0, bus.E_Busy}, 32'd0);
    bus.E_MDUOp = 4'd5;
    bus.E_A     = 32'h0000_BEEF;
    step();
    idle_inputs();
    chk("mthi_hi", bus.E_HI, 32'h0000_BEEF);

    // MULT start suppressed by E_Req, and MULT opcode without a start
    bus.E_Start = 1'b1;
    bus.E_MDUOp = 4'd1;
    bus.E_A     = 32'd9;
    bus.E_B     = 32'd9;
    bus.E_Req   = 1'b1;
    step();
    bus.E_Start = 1'b0;
    bus.E_Req   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("nolaunch_busy", {31'd0, bus.E_Busy}, 32'd0);
      step();
    end
    idle_inputs();
    chk("nolaunch_hi", bus.E_HI, 32'h0000_BEEF);
    chk("nolaunch_lo", bus.E_LO, 32'h0000_CAFE);

    // Reset mid-MULT abandons the op
    bus.E_Start = 1'b1;
    bus.E_MDUOp = 4'd1;
    bus.E_A     = 32'd4;
    bus.E_B     = 32'd5;
    step();
    idle_inputs();
    chk("rstmid_busy_t1", {31'd0, bus.E_Busy}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, bus.E_Busy}, 32'd0);
    chk("rstmid_hi", bus.E_HI, 32'd0);
    chk("rstmid_lo", bus.E_LO, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("rstmid_nocommit_lo", bus.E_LO, 32'd0);
    chk("rstmid_nocommit_busy", {31'd0, bus.E_Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit: the sequential arithmetic block that holds HI/LO.
- Reached by the same forwarded register operands that feed the decode-stage branch comparator.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage. Presents a busy handshake so hazard control stalls any later md-class instruction in D.
- Commits results to HI/LO after a fixed latency.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- E_Start  input  1  one-cycle pulse that launches MULT/MULTU/DIV/DIVU.
- E_MDUOp  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; other codes = none.
- E_A  input  32  operand rs (forwarded).
- E_B  input  32  operand rt (forwarded).
- E_Req  input  1  exception/interrupt flush; cancels this cycle's launch or MT write.
- E_Busy  output  1  high while an operation is in flight.
- E_HI  output  32  architectural HI register.
- E_LO  output  32  architectural LO register.

Behaviour:
- Reset:
  - On the rising edge with reset=1: E_Busy=0, internal cycle counter=0, pending result registers=0, E_HI=0, E_LO=0.
  - Applies mid-operation: the in-flight op is abandoned and no commit occurs.
- Launch (edge ending cycle T):
  - Conditions: E_Start=1, E_MDUOp in 1..4, E_Busy=0, E_Req=0.
  - E_A/E_B are sampled and the full result is computed into pending registers.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES.
  - E_Busy=1 from cycle T+1.
- Countdown:
  - Counter decrements each edge while busy.
  - On the edge where counter==1: pending HI/LO copied to E_HI/E_LO and E_Busy cleared.
  - So busy is high for exactly N cycles (T+1..T+N), and the new HI/LO is visible from T+N+1.
- Hazard contract: downstream stall logic uses (E_Start | E_Busy). The unit itself never waits.
- Start while busy: ignored; E_A/E_B are not resampled and the in-flight op is undisturbed.
- MTHI/MTLO:
  - When E_MDUOp=5/6, E_Busy=0 and E_Req=0, E_A is written to E_HI/E_LO on that edge.
  - No busy phase. Ignored if busy.
- E_Req=1: suppresses launch and MT writes in the same cycle only. An op already in flight continues and commits normally.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 -> 64; same split.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
- Boundary cases:
  - Divide by zero (E_B=0): full DIV_CYCLES busy period still runs; E_HI/E_LO keep their prior values (no commit).
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap.
  - E_MDUOp=1..4 without E_Start=1: no launch.
- E_HI/E_LO are registered outputs. No same-cycle bypass of pending values.

Test Plan:
- reset=1 for 2 cycles, then MULT with A=0xFFFFFFFE (-2), B=3 launched at T -> E_Busy=1 for T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy 5 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> 10 busy cycles; HI/LO unchanged.
- DIV launched; at T+3 assert E_Start with MULT, then MTHI A=0x1234 -> both ignored; DIV result commits at T+11 exactly as if undisturbed.
- MTLO A=0xCAFE with E_Req=1 -> LO unchanged. Same with E_Req=0 -> LO=0x0000CAFE next cycle, busy stays 0. MULT with E_Start=1, E_Req=1 -> busy never rises.
- MULT launched, reset=1 at T+2 -> next cycle busy=0, HI=LO=0. No commit at T+6.
